addsub_pipe: RTL
================

# addsub_pipe

Parametrised, pipelined add/subtract unit. Generalises the registered 16-bit adder datapath:
- configurable operand width;
- carry chain segmented across pipeline stages;
- add/subtract op select;
- signed-overflow and zero flags;
- valid/ready handshakes with back-pressure on both sides.

It sits between operand-producing logic (register file or sequencer) and a result consumer, and replaces the hand-enabled A/B/result register scheme with flow-controlled transfers.

## Interface
- WIDTH, 16, operand and result width; must be a multiple of SEG_WIDTH.
- SEG_WIDTH, 8, bits added per pipeline stage; NSEG = WIDTH/SEG_WIDTH stages.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rstn  in  1  reset, synchronous, active-low.
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  unit can accept a bundle this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- op  in  1  0 = add, 1 = subtract.
- cin  in  1  carry-in; for subtract, 1 = no borrow-in.
- out_valid  out  1  result bundle valid.
- out_ready  in  1  consumer accepts result this cycle.
- result  out  WIDTH  sum/difference.
- cout  out  1  unsigned carry-out; for subtract, 1 = no borrow.
- ovf  out  1  two's-complement signed overflow.
- zero  out  1  result == 0 (after saturation, if enabled).

## Operation
- Transfer in: the rising edge where in_valid & in_ready are both 1. Transfer out: the rising edge where out_valid & out_ready are both 1.
- Arithmetic:
  - add: result = a + b + cin.
  - subtract: result = a + ~b + cin.
  - Computed at WIDTH+1 bits; bit WIDTH is cout.
  - ovf = (a_msb == b'_msb) & (result_msb != a_msb), where b' is b for add and ~b for subtract.
- Stage k (0..NSEG-1) adds segment k plus the carry from stage k-1. Higher operand segments travel with the bundle; lower result segments accumulate in the stage registers.
- Global stall: advance = !out_valid | out_ready; in_ready = advance.
  - When advance = 1, every stage register and its valid bit shift by one.
  - When advance = 0, all stages hold.
  - No bubbles are inserted while out_ready stays high. Throughput is 1 bundle/cycle.
- Results leave strictly in acceptance order; no bundle is lost or duplicated.
- Outputs (result, cout, ovf, zero) are registered from the last stage and stay stable while out_valid & !out_ready.

## Timing
- Latency: a bundle accepted at edge t is presented with out_valid = 1 after edge t+NSEG-1. With the defaults (NSEG = 2), the result is visible in the cycle after acceptance.
- NSEG = 1 degenerates to a single registered adder with 1-cycle latency.
- in_ready is combinational from out_valid and out_ready; there is no other comb path from inputs to outputs.
- Reset:
  - While rstn = 0 at an edge, all stage valid bits clear and all data/flag registers load 0.
  - Effect on outputs: out_valid = 0, result = 0, cout = ovf = 0, zero = 0.
  - in_ready = 1 during and after reset.
  - Reset mid-operation discards all in-flight bundles.
  - in_valid is ignored on the reset edge.
- Simultaneous input and output transfer in the same cycle is legal and required at full throughput.
- Inputs are sampled only on transfer edges. a, b, op and cin may change freely otherwise.

## Configuration
- ADDSUB_PIPE_SAT_EN: when defined, the final stage applies signed saturation on overflow.
  - Positive overflow → 0x7F..F.
  - Negative overflow → 0x80..0.
  - ovf and cout still report the raw (unsaturated) condition; zero reflects the saturated result.
- Without the macro, the result wraps modulo 2^WIDTH. No saturation logic is synthesised.

## Structure
- Shared package addsub_pipe_pkg:
  - op encoding constants (OP_ADD = 0, OP_SUB = 1);
  - function computing NSEG from WIDTH and SEG_WIDTH;
  - elaboration-time check that WIDTH % SEG_WIDTH == 0.
- One sub-module, addsub_seg: SEG_WIDTH-bit adder with carry-in/carry-out plus its stage registers, instantiated NSEG times through a generate loop.
- Saturation and flag logic live in the top level after the last stage.

## Test plan
Defaults (WIDTH = 16, SEG_WIDTH = 8) unless stated.

1. Reset: hold rstn = 0 for 2 cycles with in_valid = 1 → out_valid = 0, result = 0x0000, in_ready = 1. No output appears after release.
2. Cross-segment carry: add 0x00FF + 0x0001, cin = 0 → one cycle later result = 0x0100, cout = 0, ovf = 0, zero = 0.
3. Subtract with borrow: 0x0005 − 0x0007, op = 1, cin = 1 → result = 0xFFFE, cout = 0, ovf = 0. Then 0x1234 − 0x1234 → 0x0000, zero = 1, cout = 1.
4. Overflow: 0x7FFF + 0x0001 → ovf = 1, result = 0x8000 without macro, 0x7FFF with ADDSUB_PIPE_SAT_EN. Also 0x8000 − 0x0001 → 0x7FFF unsaturated, 0x8000 saturated.
5. Back-pressure: 6 back-to-back bundles, out_ready low for 3 cycles mid-stream → in_ready low exactly while out_valid & !out_ready, outputs held stable, all 6 results in order, none duplicated. Repeat with WIDTH = 32, SEG_WIDTH = 8: latency is 4 cycles, and 0x0000FFFF + 1 = 0x00010000.
6. Reset mid-operation: 2 bundles in flight, then rstn = 0 for one edge → out_valid = 0 on the next cycle, neither result ever presented, and a new bundle afterwards completes normally.

Source files
------------

// File: rtl/addsub_pipe_pkg.sv
// rtl/addsub_pipe_pkg.sv - op encodings and segment-count helpers for addsub_pipe
package addsub_pipe_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int calc_nseg(input int width, input int seg_width);
    return width / seg_width;
  endfunction

  // Used by the top level to refuse a width that does not split into whole segments.
  function automatic bit seg_cfg_ok(input int width, input int seg_width);
    return (seg_width > 0) && (width >= seg_width) && ((width % seg_width) == 0);
  endfunction

endpackage

// File: rtl/addsub_seg.sv
// rtl/addsub_seg.sv - one SEG_WIDTH slice of the carry chain plus its stage registers
module addsub_seg #(
  parameter int WIDTH     = 16,
  parameter int SEG_WIDTH = 8,
  parameter int IDX       = 0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             advance,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] bx_in,
  input  logic             carry_in,
  input  logic [WIDTH-1:0] res_in,
  output logic             valid_out,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] bx_out,
  output logic             carry_out,
  output logic [WIDTH-1:0] res_out
);

  localparam int LO = IDX * SEG_WIDTH;

  logic [SEG_WIDTH:0] sum;
  logic [WIDTH-1:0]   res_next;

  always_comb begin
    sum = {1'b0, a_in[LO +: SEG_WIDTH]} + {1'b0, bx_in[LO +: SEG_WIDTH]}
        + {{SEG_WIDTH{1'b0}}, carry_in};
    res_next = res_in;
    res_next[LO +: SEG_WIDTH] = sum[SEG_WIDTH-1:0];
  end

  // Operands travel whole so later slices and the flag logic still see their bits.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid_out <= 1'b0;
      a_out     <= '0;
      bx_out    <= '0;
      carry_out <= 1'b0;
      res_out   <= '0;
    end else if (advance) begin
      valid_out <= valid_in;
      a_out     <= a_in;
      bx_out    <= bx_in;
      carry_out <= sum[SEG_WIDTH];
      res_out   <= res_next;
    end
  end

endmodule

// File: rtl/addsub_pipe.sv
// rtl/addsub_pipe.sv - pipelined add/subtract with segmented carry; ADDSUB_PIPE_SAT_EN adds signed saturation
module addsub_pipe
  import addsub_pipe_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int SEG_WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NSEG = calc_nseg(WIDTH, SEG_WIDTH);

  if (!seg_cfg_ok(WIDTH, SEG_WIDTH)) begin : g_cfg_err
    $error("addsub_pipe: WIDTH must be a non-zero multiple of SEG_WIDTH");
  end

  logic             advance;
  logic             valid_s [0:NSEG];
  logic [WIDTH-1:0] a_s     [0:NSEG];
  logic [WIDTH-1:0] bx_s    [0:NSEG];
  logic             carry_s [0:NSEG];
  logic [WIDTH-1:0] res_s   [0:NSEG];
  logic [WIDTH-1:0] bx0;

  // One global stall: the whole pipe moves only when the output slot frees up.
  assign advance  = !out_valid | out_ready;
  assign in_ready = advance;

  always_comb begin
    bx0 = b;
    case (op)
      OP_ADD: bx0 = b;
      OP_SUB: bx0 = ~b;
    endcase
  end

  assign valid_s[0] = in_valid;
  assign a_s[0]     = a;
  assign bx_s[0]    = bx0;
  assign carry_s[0] = cin;
  assign res_s[0]   = '0;

  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    addsub_seg #(
      .WIDTH    (WIDTH),
      .SEG_WIDTH(SEG_WIDTH),
      .IDX      (k)
    ) u_seg (
      .clk      (clk),
      .rstn     (rstn),
      .advance  (advance),
      .valid_in (valid_s[k]),
      .a_in     (a_s[k]),
      .bx_in    (bx_s[k]),
      .carry_in (carry_s[k]),
      .res_in   (res_s[k]),
      .valid_out(valid_s[k+1]),
      .a_out    (a_s[k+1]),
      .bx_out   (bx_s[k+1]),
      .carry_out(carry_s[k+1]),
      .res_out  (res_s[k+1])
    );
  end

  logic [WIDTH-1:0] raw;
  logic             a_msb;
  logic             bx_msb;
  logic             ovf_raw;

  assign raw     = res_s[NSEG];
  assign a_msb   = a_s[NSEG][WIDTH-1];
  assign bx_msb  = bx_s[NSEG][WIDTH-1];
  assign ovf_raw = (a_msb == bx_msb) & (raw[WIDTH-1] != a_msb);

`ifdef ADDSUB_PIPE_SAT_EN
  // On overflow both operands share a sign, so a_msb picks the clamp direction.
  always_comb begin
    result = raw;
    if (ovf_raw) begin
      result = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign result = raw;
`endif

  assign out_valid = valid_s[NSEG];
  assign cout      = carry_s[NSEG];
  assign ovf       = ovf_raw;
  assign zero      = out_valid & (result == '0);

endmodule
